// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one req/gnt/rvalid bus transaction per load or store,
// with alignment/funct3 checking, byte-lane steering, load extension and a response timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  output logic        lsu_busy,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        lsu_err,
  output logic [31:0] err_addr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StReq, StResp, StDone, StErr} state_t;

  state_t          state;
  logic [31:0]     op_addr;
  logic [2:0]      op_funct3;
  logic            op_load;
  logic            op_m2r;
  logic [4:0]      op_rd;
  logic [CntW-1:0] cnt;

  logic        accept;
  logic        legal_f3;
  logic        misalign;
  logic        acc_err;
  logic        finish;
  logic        expire;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] rshift;
  logic [31:0] load_data;

  assign accept = (state == StIdle) && ex_valid && (mem_read || mem_write);

  always_comb begin
    legal_f3 = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
      3'b100, 3'b101:         legal_f3 = mem_read;
      default:                legal_f3 = 1'b0;
    endcase
  end

  assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign acc_err  = (mem_read && mem_write) || !legal_f3 || misalign;

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << addr[1:0];
        wdata_next = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign rshift = bus_rdata >> {op_addr[1:0], 3'b000};

  always_comb begin
    load_data = rshift;
    case (op_funct3)
      3'b000:  load_data = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_data = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_data = {24'd0, rshift[7:0]};
      3'b101:  load_data = {16'd0, rshift[15:0]};
      default: load_data = rshift;
    endcase
  end

  // A grant can only complete the access together with rvalid; gnt alone stops the timer race.
  assign finish = ((state == StReq) && bus_gnt && bus_rvalid) ||
                  ((state == StResp) && bus_rvalid);
  assign expire = (((state == StReq) && !bus_gnt) || ((state == StResp) && !bus_rvalid)) &&
                  (cnt == CntLast);

  assign lsu_busy = reset_n && (accept || (state == StReq) || (state == StResp));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= StIdle;
      op_addr   <= '0;
      op_funct3 <= '0;
      op_load   <= 1'b0;
      op_m2r    <= 1'b0;
      op_rd     <= '0;
      cnt       <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      lsu_err   <= 1'b0;
      err_addr  <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      lsu_err  <= 1'b0;
      if (finish) begin
        state    <= StDone;
        bus_req  <= 1'b0;
        wb_valid <= 1'b1;
        wb_we    <= op_load && op_m2r && (op_rd != 5'd0);
        wb_rd    <= op_rd;
        if (op_load) wb_data <= load_data;
      end else if (expire) begin
        state    <= StErr;
        bus_req  <= 1'b0;
        lsu_err  <= 1'b1;
        err_addr <= op_addr;
      end else begin
        case (state)
          StIdle: begin
            if (accept) begin
              op_addr   <= addr;
              op_funct3 <= funct3;
              op_load   <= mem_read;
              op_m2r    <= mem_to_reg;
              op_rd     <= rd;
              cnt       <= '0;
              if (acc_err) begin
                state    <= StErr;
                lsu_err  <= 1'b1;
                err_addr <= addr;
              end else begin
                state     <= StReq;
                bus_req   <= 1'b1;
                bus_we    <= mem_write;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_be    <= be_next;
                bus_wdata <= wdata_next;
              end
            end
          end
          StReq: begin
            cnt <= cnt + 1'b1;
            if (bus_gnt) begin
              state   <= StResp;
              bus_req <= 1'b0;
            end
          end
          StResp:  cnt <= cnt + 1'b1;
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized accesses
// compared against a byte-lane reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_to_reg = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [4:0]  rd = '0;
  logic        lsu_busy, wb_valid, wb_we, lsu_err, bus_req, bus_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, err_addr, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rd(rd), .lsu_busy(lsu_busy), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .lsu_err(lsu_err), .err_addr(err_addr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_legal(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    int n;
    if (f3[1:0] == 2'b11) return 1'b0;
    if (f3[2] && (!ld || f3[1])) return 1'b0;
    n = 1 << f3[1:0];
    return (int'(a[1:0]) % n) == 0;
  endfunction

  task automatic drive(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] r, input bit m2r);
    ex_valid = 1'b1; mem_read = ld; mem_write = st; mem_to_reg = m2r;
    funct3 = f3; addr = a; wdata = wd; rd = r;
  endtask

  task automatic release_ex();
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // One legal access; bus waits gdly cycles for gnt, then rvalid rdly cycles after gnt.
  task automatic do_txn(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] r, input bit m2r,
                        input int gdly, input int rdly, input logic [31:0] rdat);
    logic [3:0]  be_e;
    logic [31:0] wd_e, ld_e;
    logic [37:0] bus_e;
    int n, off;
    n = 1 << f3[1:0];
    off = int'(a[1:0]);
    be_e = '0;
    wd_e = '0;
    ld_e = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + n) be_e[i] = 1'b1;
      wd_e[8*i +: 8] = wd[8*(i % n) +: 8];
    end
    for (int k = 0; k < n; k++) ld_e[8*k +: 8] = rdat[8*(off+k) +: 8];
    if (!f3[2] && n < 4 && ld_e[8*n-1]) for (int k = n; k < 4; k++) ld_e[8*k +: 8] = 8'hff;
    bus_e = {1'b1, !ld, a[31:2], 2'b00, be_e};

    drive(ld, !ld, f3, a, wd, r, m2r);
    #1;
    checks++; if (lsu_busy !== 1'b1) begin errors++; $display("FAIL accept_busy got %0b want 1", lsu_busy); end
    step();
    for (int c = 0; c <= gdly; c++) begin
      checks++;
      if ({bus_req, bus_we, bus_addr, bus_be} !== bus_e) begin
        errors++; $display("FAIL bus_req_phase got %h want %h", {bus_req, bus_we, bus_addr, bus_be}, bus_e);
      end
      if (!ld) begin
        checks++; if (bus_wdata !== wd_e) begin errors++; $display("FAIL bus_wdata got %h want %h", bus_wdata, wd_e); end
      end
      checks++; if (lsu_busy !== 1'b1) begin errors++; $display("FAIL req_busy got %0b want 1", lsu_busy); end
      bus_rdata = $urandom;
      if (c == gdly) begin
        bus_gnt = 1'b1;
        bus_rvalid = (rdly == 0);
        if (rdly == 0) bus_rdata = rdat;
      end
      step();
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
    end
    for (int c = 1; c <= rdly; c++) begin
      checks++;
      if ({lsu_busy, bus_req, wb_valid} !== 3'b100) begin
        errors++; $display("FAIL resp_phase got %b want 100", {lsu_busy, bus_req, wb_valid});
      end
      if (c == rdly) begin bus_rvalid = 1'b1; bus_rdata = rdat; end
      step();
      bus_rvalid = 1'b0; bus_rdata = $urandom;
    end
    checks++;
    if ({wb_valid, wb_we, wb_rd, lsu_busy, lsu_err} !== {1'b1, ld && m2r && r != 0, r, 2'b00}) begin
      errors++; $display("FAIL done_flags got %b want %b", {wb_valid, wb_we, wb_rd, lsu_busy, lsu_err},
                         {1'b1, ld && m2r && r != 0, r, 2'b00});
    end
    if (ld) begin
      checks++; if (wb_data !== ld_e) begin errors++; $display("FAIL wb_data got %h want %h", wb_data, ld_e); end
    end
    step();
    release_ex();
    #1;
    checks++;
    if ({wb_valid, wb_we, wb_rd, lsu_busy} !== {2'b00, r, 1'b0}) begin
      errors++; $display("FAIL after_done got %b want %b", {wb_valid, wb_we, wb_rd, lsu_busy}, {2'b00, r, 1'b0});
    end
    if (ld) begin
      checks++; if (wb_data !== ld_e) begin errors++; $display("FAIL wb_data_hold got %h want %h", wb_data, ld_e); end
    end
  endtask

  task automatic do_err(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a);
    drive(ld, st, f3, a, $urandom, 5'd7, 1'b1);
    #1;
    checks++; if (lsu_busy !== 1'b1) begin errors++; $display("FAIL err_accept_busy got %0b want 1", lsu_busy); end
    step();
    checks++;
    if ({lsu_err, bus_req, wb_valid, lsu_busy} !== 4'b1000) begin
      errors++; $display("FAIL err_pulse got %b want 1000", {lsu_err, bus_req, wb_valid, lsu_busy});
    end
    checks++; if (err_addr !== a) begin errors++; $display("FAIL err_addr got %h want %h", err_addr, a); end
    step();
    release_ex();
    #1;
    checks++;
    if ({lsu_err, bus_req, wb_valid, lsu_busy} !== 4'b0000) begin
      errors++; $display("FAIL err_after got %b want 0000", {lsu_err, bus_req, wb_valid, lsu_busy});
    end
    checks++; if (err_addr !== a) begin errors++; $display("FAIL err_addr_hold got %h want %h", err_addr, a); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    checks++;
    if ({lsu_busy, wb_valid, wb_we, wb_rd, wb_data, lsu_err, err_addr, bus_req, bus_we,
         bus_addr, bus_be, bus_wdata} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero busy=%0b req=%0b wb_data=%h err_addr=%h",
                         lsu_busy, bus_req, wb_data, err_addr);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_directed_loads();
    do_txn(1'b1, 3'b010, 32'h100, '0, 5'd5, 1'b1, 0, 1, 32'hDEADBEEF);
    do_txn(1'b1, 3'b000, 32'h103, '0, 5'd6, 1'b1, 0, 1, 32'h80123456);
    do_txn(1'b1, 3'b100, 32'h103, '0, 5'd6, 1'b1, 0, 1, 32'h80123456);
    do_txn(1'b1, 3'b101, 32'h102, '0, 5'd9, 1'b1, 1, 2, 32'hBEEF0000);
    do_txn(1'b1, 3'b010, 32'h104, '0, 5'd0, 1'b1, 0, 0, 32'h13579BDF);
  endtask

  task automatic test_store();
    do_txn(1'b0, 3'b001, 32'h202, 32'h1234ABCD, 5'd3, 1'b0, 3, 1, 32'h0);
    do_txn(1'b0, 3'b000, 32'h301, 32'h000000A5, 5'd3, 1'b0, 0, 0, 32'h0);
  endtask

  task automatic test_errors();
    do_err(1'b1, 1'b0, 3'b010, 32'h101);
    do_err(1'b1, 1'b1, 3'b010, 32'h101);
    do_err(1'b0, 1'b1, 3'b100, 32'h200);
    do_err(1'b1, 1'b0, 3'b001, 32'h203);
  endtask

  task automatic test_timeout();
    int reqs;
    bit seen;
    reqs = 0;
    seen = 1'b0;
    drive(1'b1, 1'b0, 3'b010, 32'h400, '0, 5'd4, 1'b1);
    step();
    for (int c = 0; c < 40 && !seen; c++) begin
      if (lsu_err) seen = 1'b1;
      else begin
        if (bus_req) reqs++;
        step();
      end
    end
    checks++;
    if ({seen, bus_req} !== 2'b10 || reqs != 16) begin
      errors++; $display("FAIL timeout got seen=%0b req=%0b reqs=%0d want seen=1 req=0 reqs=16",
                         seen, bus_req, reqs);
    end
    checks++; if (err_addr !== 32'h400) begin errors++; $display("FAIL timeout_addr got %h want 400", err_addr); end
    step();
    release_ex();
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    step();
    bus_rvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({wb_valid, lsu_err, lsu_busy, bus_req} !== 4'b0000) begin
        errors++; $display("FAIL stray_rvalid got %b want 0000", {wb_valid, lsu_err, lsu_busy, bus_req});
      end
      step();
    end
    do_txn(1'b1, 3'b010, 32'h404, '0, 5'd8, 1'b1, 0, 1, 32'h0BADC0DE);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 3'b010, 32'h500, '0, 5'd2, 1'b1);
    step();
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus_req, lsu_busy} !== 2'b00) begin
      errors++; $display("FAIL reset_in_req got %b want 00", {bus_req, lsu_busy});
    end
    release_ex();
    step();
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 3'b010, 32'h504, '0, 5'd2, 1'b1);
    step();
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({lsu_busy, wb_valid, wb_we, lsu_err, bus_req, bus_be, err_addr, bus_addr} !== '0) begin
      errors++; $display("FAIL reset_in_resp got busy=%0b req=%0b be=%b bus_addr=%h",
                         lsu_busy, bus_req, bus_be, bus_addr);
    end
    release_ex();
    step();
    reset_n = 1'b1;
    bus_rvalid = 1'b1;
    step();
    bus_rvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({wb_valid, lsu_err} !== 2'b00) begin
        errors++; $display("FAIL post_reset_quiet got %b want 00", {wb_valid, lsu_err});
      end
      step();
    end
    do_txn(1'b1, 3'b010, 32'h508, '0, 5'd0, 1'b1, 0, 1, 32'h55AA55AA);
  endtask

  task automatic test_random();
    bit ld, both;
    logic [2:0] f3;
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      ld = $urandom_range(0, 1);
      both = ($urandom_range(0, 9) == 0);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if (both) do_err(1'b1, 1'b1, f3, a);
      else if (!is_legal(ld, f3, a)) do_err(ld, !ld, f3, a);
      else do_txn(ld, f3, a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 4), $urandom_range(0, 4), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_directed_loads();
    test_store();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
